// File: rtl/ips2l_pcie_dma_rx_bar_wr_router_pkg.sv
// Shared constants and helpers for the DMA RX BAR write router.
//   SRC_MWR / SRC_CPLD : source indices, used for o_ovf bit positions and rr_prio encoding
//   HIT_W              : width of the bar_hit field carried with each beat
//   CNT_W              : width of the drop counter
//   sat_add            : saturating add of a 0..2 increment to a CNT_W-bit counter
package ips2l_pcie_dma_rx_bar_wr_router_pkg;

    localparam int unsigned SRC_MWR  = 0;
    localparam int unsigned SRC_CPLD = 1;
    localparam int unsigned HIT_W    = 3;
    localparam int unsigned CNT_W    = 16;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(inc);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/ips2l_pcie_dma_sync_fifo.sv
// Single-clock FIFO, DEPTH a power of two (>= 2).
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data; ignored while full
//   pop        : read request; ignored while empty
//   full/empty : status flags
//   dout       : head entry (valid while !empty)
module ips2l_pcie_dma_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
        dout    = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/ips2l_pcie_dma_rx_bar_wr_router.sv
// DMA RX BAR write router. Buffers MWR and CPLD write beats in per-source FIFOs and
// steers each head beat to the BAR port named by its bar_hit, with per-BAR ready.
//   clk, rst_n            : core clock, asynchronous active-low reset
//   i_mwr_wr_* / o_mwr_*  : MWR beat push (en/addr/data/be/bar_hit) and FIFO-not-full
//   i_cpld_wr_* / o_cpld_*: CPLD beat push and FIFO-not-full
//   o_bar_wr_*            : registered per-BAR write strobe, flattened addr/data/be lanes
//   i_bar_wr_rdy          : per-BAR ready; ready at t guarantees acceptance at t+1
//   i_stat_clr            : clears o_ovf and o_drop_cnt (wins over same-cycle events)
//   o_ovf                 : sticky push-while-full flags, [0]=MWR [1]=CPLD
//   o_drop_cnt            : saturating count of beats with bar_hit >= NUM_BAR
module ips2l_pcie_dma_rx_bar_wr_router
    import ips2l_pcie_dma_rx_bar_wr_router_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 128,
    parameter int NUM_BAR    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_mwr_wr_en,
    input  logic [ADDR_WIDTH-1:0]            i_mwr_wr_addr,
    input  logic [DATA_WIDTH-1:0]            i_mwr_wr_data,
    input  logic [DATA_WIDTH/8-1:0]          i_mwr_wr_be,
    input  logic [2:0]                       i_mwr_wr_bar_hit,
    output logic                             o_mwr_wr_rdy,
    input  logic                             i_cpld_wr_en,
    input  logic [ADDR_WIDTH-1:0]            i_cpld_wr_addr,
    input  logic [DATA_WIDTH-1:0]            i_cpld_wr_data,
    input  logic [DATA_WIDTH/8-1:0]          i_cpld_wr_be,
    input  logic [2:0]                       i_cpld_wr_bar_hit,
    output logic                             o_cpld_wr_rdy,
    output logic [NUM_BAR-1:0]               o_bar_wr_en,
    output logic [NUM_BAR*ADDR_WIDTH-1:0]    o_bar_wr_addr,
    output logic [NUM_BAR*DATA_WIDTH-1:0]    o_bar_wr_data,
    output logic [NUM_BAR*DATA_WIDTH/8-1:0]  o_bar_wr_be,
    input  logic [NUM_BAR-1:0]               i_bar_wr_rdy,
    input  logic                             i_stat_clr,
    output logic [1:0]                       o_ovf,
    output logic [15:0]                      o_drop_cnt
);

    localparam int BEW = DATA_WIDTH / 8;
    localparam int EW  = ADDR_WIDTH + DATA_WIDTH + BEW + HIT_W;

    logic               m_full, m_empty, m_pop;
    logic               c_full, c_empty, c_pop;
    logic [EW-1:0]      m_dout, c_dout;
    logic [HIT_W-1:0]   m_hit, c_hit;
    logic [ADDR_WIDTH-1:0] m_addr, c_addr;
    logic [DATA_WIDTH-1:0] m_data, c_data;
    logic [BEW-1:0]     m_be, c_be;
    logic               m_hit_ok, c_hit_ok, m_tgt_rdy, c_tgt_rdy;
    logic               m_elig, c_elig, conflict, m_issue, c_issue;
    logic               m_sel, c_sel;
    logic [1:0]         ovf_evt;

    logic                            rr_prio_q, rr_prio_d;
    logic [NUM_BAR-1:0]              bar_wr_en_q, bar_wr_en_d;
    logic [NUM_BAR*ADDR_WIDTH-1:0]   bar_wr_addr_q, bar_wr_addr_d;
    logic [NUM_BAR*DATA_WIDTH-1:0]   bar_wr_data_q, bar_wr_data_d;
    logic [NUM_BAR*BEW-1:0]          bar_wr_be_q, bar_wr_be_d;
    logic [1:0]                      ovf_q, ovf_d;
    logic [CNT_W-1:0]                drop_cnt_q, drop_cnt_d;

    ips2l_pcie_dma_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_mwr_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (i_mwr_wr_en && !m_full),
        .din   ({i_mwr_wr_bar_hit, i_mwr_wr_addr, i_mwr_wr_data, i_mwr_wr_be}),
        .pop   (m_pop),
        .full  (m_full),
        .empty (m_empty),
        .dout  (m_dout)
    );

    ips2l_pcie_dma_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_cpld_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (i_cpld_wr_en && !c_full),
        .din   ({i_cpld_wr_bar_hit, i_cpld_wr_addr, i_cpld_wr_data, i_cpld_wr_be}),
        .pop   (c_pop),
        .full  (c_full),
        .empty (c_empty),
        .dout  (c_dout)
    );

    // Head decode and arbitration.
    always_comb begin
        {m_hit, m_addr, m_data, m_be} = m_dout;
        {c_hit, c_addr, c_data, c_be} = c_dout;
        m_hit_ok  = ({1'b0, m_hit} < 4'(NUM_BAR));
        c_hit_ok  = ({1'b0, c_hit} < 4'(NUM_BAR));
        m_tgt_rdy = 1'b0;
        c_tgt_rdy = 1'b0;
        for (int b = 0; b < NUM_BAR; b++) begin
            if (m_hit == HIT_W'(b)) m_tgt_rdy = i_bar_wr_rdy[b];
            if (c_hit == HIT_W'(b)) c_tgt_rdy = i_bar_wr_rdy[b];
        end
        m_elig   = !m_empty && m_hit_ok && m_tgt_rdy;
        c_elig   = !c_empty && c_hit_ok && c_tgt_rdy;
        conflict = m_elig && c_elig && (m_hit == c_hit);
        m_issue  = m_elig && (!conflict || (rr_prio_q == 1'(SRC_MWR)));
        c_issue  = c_elig && (!conflict || (rr_prio_q == 1'(SRC_CPLD)));
        // Priority only moves on an actual collision, handing it to the loser.
        rr_prio_d = conflict ? ~rr_prio_q : rr_prio_q;
        // Invalid-BAR heads are popped and dropped unconditionally.
        m_pop = !m_empty && (!m_hit_ok || m_issue);
        c_pop = !c_empty && (!c_hit_ok || c_issue);
    end

    // Output lane build: at most one source can select a given BAR after arbitration.
    always_comb begin
        bar_wr_en_d   = '0;
        bar_wr_addr_d = '0;
        bar_wr_data_d = '0;
        bar_wr_be_d   = '0;
        m_sel         = 1'b0;
        c_sel         = 1'b0;
        for (int b = 0; b < NUM_BAR; b++) begin
            m_sel = m_issue && (m_hit == HIT_W'(b));
            c_sel = c_issue && (c_hit == HIT_W'(b));
            bar_wr_en_d[b] = m_sel || c_sel;
            if (m_sel) begin
                bar_wr_addr_d[b*ADDR_WIDTH +: ADDR_WIDTH] = m_addr;
                bar_wr_data_d[b*DATA_WIDTH +: DATA_WIDTH] = m_data;
                bar_wr_be_d[b*BEW +: BEW]                 = m_be;
            end else if (c_sel) begin
                bar_wr_addr_d[b*ADDR_WIDTH +: ADDR_WIDTH] = c_addr;
                bar_wr_data_d[b*DATA_WIDTH +: DATA_WIDTH] = c_data;
                bar_wr_be_d[b*BEW +: BEW]                 = c_be;
            end
        end
    end

    // Status: clear has priority over same-cycle events.
    always_comb begin
        ovf_evt           = '0;
        ovf_evt[SRC_MWR]  = i_mwr_wr_en && m_full;
        ovf_evt[SRC_CPLD] = i_cpld_wr_en && c_full;
        if (i_stat_clr) begin
            ovf_d      = '0;
            drop_cnt_d = '0;
        end else begin
            ovf_d      = ovf_q | ovf_evt;
            drop_cnt_d = sat_add(drop_cnt_q, {1'b0, !m_empty && !m_hit_ok}
                                             + {1'b0, !c_empty && !c_hit_ok});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_prio_q     <= 1'(SRC_MWR);
            bar_wr_en_q   <= '0;
            bar_wr_addr_q <= '0;
            bar_wr_data_q <= '0;
            bar_wr_be_q   <= '0;
            ovf_q         <= '0;
            drop_cnt_q    <= '0;
        end else begin
            rr_prio_q     <= rr_prio_d;
            bar_wr_en_q   <= bar_wr_en_d;
            bar_wr_addr_q <= bar_wr_addr_d;
            bar_wr_data_q <= bar_wr_data_d;
            bar_wr_be_q   <= bar_wr_be_d;
            ovf_q         <= ovf_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign o_mwr_wr_rdy  = !m_full;
    assign o_cpld_wr_rdy = !c_full;
    assign o_bar_wr_en   = bar_wr_en_q;
    assign o_bar_wr_addr = bar_wr_addr_q;
    assign o_bar_wr_data = bar_wr_data_q;
    assign o_bar_wr_be   = bar_wr_be_q;
    assign o_ovf         = ovf_q;
    assign o_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_ips2l_pcie_dma_rx_bar_wr_router.sv
// Directed bench for the DMA RX BAR write router (NUM_BAR=4, FIFO_DEPTH=4).
module tb_ips2l_pcie_dma_rx_bar_wr_router;

    localparam int AW  = 9;
    localparam int DW  = 128;
    localparam int NB  = 4;
    localparam int BEW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_mwr_wr_en, i_cpld_wr_en;
    logic [AW-1:0]     i_mwr_wr_addr, i_cpld_wr_addr;
    logic [DW-1:0]     i_mwr_wr_data, i_cpld_wr_data;
    logic [BEW-1:0]    i_mwr_wr_be, i_cpld_wr_be;
    logic [2:0]        i_mwr_wr_bar_hit, i_cpld_wr_bar_hit;
    logic              o_mwr_wr_rdy, o_cpld_wr_rdy;
    logic [NB-1:0]     o_bar_wr_en;
    logic [NB*AW-1:0]  o_bar_wr_addr;
    logic [NB*DW-1:0]  o_bar_wr_data;
    logic [NB*BEW-1:0] o_bar_wr_be;
    logic [NB-1:0]     i_bar_wr_rdy;
    logic              i_stat_clr;
    logic [1:0]        o_ovf;
    logic [15:0]       o_drop_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ips2l_pcie_dma_rx_bar_wr_router #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_BAR    (NB),
        .FIFO_DEPTH (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_mwr_wr_en       (i_mwr_wr_en),
        .i_mwr_wr_addr     (i_mwr_wr_addr),
        .i_mwr_wr_data     (i_mwr_wr_data),
        .i_mwr_wr_be       (i_mwr_wr_be),
        .i_mwr_wr_bar_hit  (i_mwr_wr_bar_hit),
        .o_mwr_wr_rdy      (o_mwr_wr_rdy),
        .i_cpld_wr_en      (i_cpld_wr_en),
        .i_cpld_wr_addr    (i_cpld_wr_addr),
        .i_cpld_wr_data    (i_cpld_wr_data),
        .i_cpld_wr_be      (i_cpld_wr_be),
        .i_cpld_wr_bar_hit (i_cpld_wr_bar_hit),
        .o_cpld_wr_rdy     (o_cpld_wr_rdy),
        .o_bar_wr_en       (o_bar_wr_en),
        .o_bar_wr_addr     (o_bar_wr_addr),
        .o_bar_wr_data     (o_bar_wr_data),
        .o_bar_wr_be       (o_bar_wr_be),
        .i_bar_wr_rdy      (i_bar_wr_rdy),
        .i_stat_clr        (i_stat_clr),
        .o_ovf             (o_ovf),
        .o_drop_cnt        (o_drop_cnt)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mwr(input logic en, input logic [2:0] hit, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data, input logic [BEW-1:0] be);
        i_mwr_wr_en = en; i_mwr_wr_bar_hit = hit; i_mwr_wr_addr = addr;
        i_mwr_wr_data = data; i_mwr_wr_be = be;
    endtask

    task automatic cpld(input logic en, input logic [2:0] hit, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [BEW-1:0] be);
        i_cpld_wr_en = en; i_cpld_wr_bar_hit = hit; i_cpld_wr_addr = addr;
        i_cpld_wr_data = data; i_cpld_wr_be = be;
    endtask

    logic [DW-1:0]     d_a5, d_1, d_2;
    logic [NB*AW-1:0]  ea;
    logic [NB*DW-1:0]  ed;
    logic [NB*BEW-1:0] eb;
    logic [AW-1:0]     seq [8];

    initial begin
        d_a5 = {16{8'hA5}};
        d_1  = {4{32'h1111_2222}};
        d_2  = {4{32'h3333_4444}};
        seq  = '{9'h040, 9'h050, 9'h041, 9'h051, 9'h042, 9'h052, 9'h043, 9'h053};

        rst_n = 1'b0; i_bar_wr_rdy = 4'hF; i_stat_clr = 1'b0;
        mwr(1'b0, 3'd0, '0, '0, '0);
        cpld(1'b0, 3'd0, '0, '0, '0);
        step(); step();

        // Reset values
        check("rst_en", o_bar_wr_en, 4'b0000);
        check("rst_addr", o_bar_wr_addr, '0);
        check("rst_data", o_bar_wr_data, '0);
        check("rst_be", o_bar_wr_be, '0);
        check("rst_mwr_rdy", o_mwr_wr_rdy, 1'b1);
        check("rst_cpld_rdy", o_cpld_wr_rdy, 1'b1);
        check("rst_ovf", o_ovf, 2'b00);
        check("rst_drop", o_drop_cnt, 16'd0);
        rst_n = 1'b1;
        step();

        // 1) single MWR beat to BAR0, two-cycle latency
        mwr(1'b1, 3'd0, 9'h010, d_a5, 16'hFFFF);
        step();
        mwr(1'b0, 3'd0, '0, '0, '0);
        check("t1_en_early", o_bar_wr_en, 4'b0000);
        step();
        ed = '0; ed[0 +: DW] = d_a5;
        check("t1_en", o_bar_wr_en, 4'b0001);
        check("t1_addr", o_bar_wr_addr, 36'h010);
        check("t1_data", o_bar_wr_data, ed);
        check("t1_be", o_bar_wr_be, 64'hFFFF);
        step();
        check("t1_en_pulse", o_bar_wr_en, 4'b0000);

        // 2) MWR->BAR0 and CPLD->BAR2 in the same cycle
        mwr(1'b1, 3'd0, 9'h020, d_1, 16'hFFFF);
        cpld(1'b1, 3'd2, 9'h030, d_2, 16'h00F0);
        step();
        mwr(1'b0, 3'd0, '0, '0, '0);
        cpld(1'b0, 3'd0, '0, '0, '0);
        step();
        ea = '0; ea[0 +: AW] = 9'h020; ea[2*AW +: AW] = 9'h030;
        ed = '0; ed[0 +: DW] = d_1; ed[2*DW +: DW] = d_2;
        eb = '0; eb[0 +: BEW] = 16'hFFFF; eb[2*BEW +: BEW] = 16'h00F0;
        check("t2_en", o_bar_wr_en, 4'b0101);
        check("t2_addr", o_bar_wr_addr, ea);
        check("t2_data", o_bar_wr_data, ed);
        check("t2_be", o_bar_wr_be, eb);
        step();
        check("t2_en_after", o_bar_wr_en, 4'b0000);

        // 3) both sources hammer BAR2: strict alternation starting with MWR
        for (int k = 0; k < 10; k++) begin
            if (k < 4) begin
                mwr(1'b1, 3'd2, 9'h040 + 9'(k), d_1, 16'h000F);
                cpld(1'b1, 3'd2, 9'h050 + 9'(k), d_2, 16'hF000);
            end else begin
                mwr(1'b0, 3'd0, '0, '0, '0);
                cpld(1'b0, 3'd0, '0, '0, '0);
            end
            step();
            if (k >= 1 && k <= 8) begin
                check($sformatf("t3_en_%0d", k - 1), o_bar_wr_en, 4'b0100);
                check($sformatf("t3_addr_%0d", k - 1), o_bar_wr_addr[2*AW +: AW], seq[k-1]);
            end else begin
                check($sformatf("t3_idle_%0d", k), o_bar_wr_en, 4'b0000);
            end
        end

        // 4) BAR1 stalled: fill MWR FIFO, overflow the 5th beat, then drain in order
        i_bar_wr_rdy = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            mwr(1'b1, 3'd1, 9'h060 + 9'(i), d_a5, 16'h0FF0);
            step();
        end
        check("t4_full_rdy", o_mwr_wr_rdy, 1'b0);
        mwr(1'b1, 3'd1, 9'h064, d_a5, 16'h0FF0);
        step();
        mwr(1'b0, 3'd0, '0, '0, '0);
        check("t4_ovf", o_ovf, 2'b01);
        check("t4_stalled_en", o_bar_wr_en, 4'b0000);
        check("t4_still_full", o_mwr_wr_rdy, 1'b0);
        i_bar_wr_rdy = 4'hF;
        step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_en_%0d", i), o_bar_wr_en, 4'b0010);
            check($sformatf("t4_addr_%0d", i), o_bar_wr_addr[AW +: AW], 9'h060 + 9'(i));
            step();
        end
        check("t4_no_fifth", o_bar_wr_en, 4'b0000);
        check("t4_rdy_back", o_mwr_wr_rdy, 1'b1);

        // 5) invalid BAR on CPLD is dropped and counted; stat clear zeroes status
        cpld(1'b1, 3'd5, 9'h070, d_2, 16'hFFFF);
        step();
        cpld(1'b0, 3'd0, '0, '0, '0);
        check("t5_en_a", o_bar_wr_en, 4'b0000);
        step();
        check("t5_en_b", o_bar_wr_en, 4'b0000);
        check("t5_drop", o_drop_cnt, 16'd1);
        i_stat_clr = 1'b1;
        step();
        i_stat_clr = 1'b0;
        check("t5_drop_clr", o_drop_cnt, 16'd0);
        check("t5_ovf_clr", o_ovf, 2'b00);

        // 6) reset with beats buffered and a write on the outputs
        i_bar_wr_rdy = 4'b1101;
        mwr(1'b1, 3'd1, 9'h080, d_1, 16'hFFFF);
        cpld(1'b1, 3'd6, 9'h000, d_2, 16'hFFFF);
        step();
        cpld(1'b0, 3'd0, '0, '0, '0);
        mwr(1'b1, 3'd1, 9'h081, d_1, 16'hFFFF);
        step();
        mwr(1'b1, 3'd1, 9'h082, d_1, 16'hFFFF);
        step();
        mwr(1'b0, 3'd0, '0, '0, '0);
        check("t6_drop_pre", o_drop_cnt, 16'd1);
        i_bar_wr_rdy = 4'hF;
        step();
        check("t6_en_pre", o_bar_wr_en, 4'b0010);
        check("t6_addr_pre", o_bar_wr_addr[AW +: AW], 9'h080);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_en", o_bar_wr_en, 4'b0000);
        check("t6_rst_addr", o_bar_wr_addr, '0);
        check("t6_rst_data", o_bar_wr_data, '0);
        check("t6_rst_drop", o_drop_cnt, 16'd0);
        check("t6_rst_mwr_rdy", o_mwr_wr_rdy, 1'b1);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t6_quiet_%0d", i), o_bar_wr_en, 4'b0000);
        end
        mwr(1'b1, 3'd3, 9'h090, d_a5, 16'h00FF);
        step();
        mwr(1'b0, 3'd0, '0, '0, '0);
        step();
        check("t6_new_en", o_bar_wr_en, 4'b1000);
        check("t6_new_addr", o_bar_wr_addr[3*AW +: AW], 9'h090);
        check("t6_new_be", o_bar_wr_be[3*BEW +: BEW], 16'h00FF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
